// File: rtl/bit_entry_sequencer.sv
// Button-entry transmitter: replays an accepted word MSB-first as timed
// enter0/enter1 pulses followed by confirm, or a clear pulse on abort.
module bit_entry_sequencer #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH+1)-1:0] bit_count,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic                       abort,
  output logic                       enter0,
  output logic                       enter1,
  output logic                       confirm,
  output logic                       clear,
  output logic                       busy
);

  localparam int BCW  = $clog2(WIDTH + 1);
  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]  P_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  G_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(WIDTH);
  localparam logic [BCW-1:0] BC_ONE  = BCW'(1);

  typedef enum logic [2:0] {
    IDLE,
    BIT_PULSE,
    BIT_GAP,
    CONF_PULSE,
    CONF_GAP,
    CLR_PULSE,
    CLR_GAP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [BCW-1:0]   bits_left, bits_left_nx;
  logic             enter0_nx, enter1_nx, confirm_nx, clear_nx;

  // A zero or oversized request means a full-width word.
  function automatic logic [BCW-1:0] norm_count(input logic [BCW-1:0] n);
    logic [BCW-1:0] r;
    if ((n == '0) || (n > BC_FULL)) r = BC_FULL;
    else                            r = n;
    return r;
  endfunction

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    bits_left_nx = bits_left;

    case (state)
      IDLE: begin
        if (abort) begin
          state_nx     = CLR_PULSE;
          cnt_nx       = '0;
          shreg_nx     = '0;
          bits_left_nx = '0;
        end else if (data_valid) begin
          state_nx     = BIT_PULSE;
          cnt_nx       = '0;
          shreg_nx     = data_in;
          bits_left_nx = norm_count(bit_count);
        end
      end

      BIT_PULSE: begin
        if (cnt == P_LAST) begin
          state_nx = BIT_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      BIT_GAP: begin
        if (cnt == G_LAST) begin
          cnt_nx   = '0;
          shreg_nx = shreg << 1;
          // The counter saturates at zero rather than wrapping.
          if (bits_left > BC_ONE) begin
            bits_left_nx = bits_left - 1'b1;
            state_nx     = BIT_PULSE;
          end else begin
            bits_left_nx = '0;
            state_nx     = CONF_PULSE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      CONF_PULSE: begin
        if (cnt == P_LAST) begin
          state_nx = CONF_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      CONF_GAP: begin
        if (cnt == G_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      CLR_PULSE: begin
        if (cnt == P_LAST) begin
          state_nx = CLR_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      CLR_GAP: begin
        if (cnt == G_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: begin
        state_nx     = IDLE;
        cnt_nx       = '0;
        shreg_nx     = '0;
        bits_left_nx = '0;
      end
    endcase

    // Abort discards the word from any active state; clear states run to completion.
    if (abort && ((state == BIT_PULSE) || (state == BIT_GAP) ||
                  (state == CONF_PULSE) || (state == CONF_GAP))) begin
      state_nx     = CLR_PULSE;
      cnt_nx       = '0;
      shreg_nx     = '0;
      bits_left_nx = '0;
    end

    // Pulse outputs are decoded from the next state so they register in step with it.
    enter1_nx  = (state_nx == BIT_PULSE) &&  shreg_nx[WIDTH-1];
    enter0_nx  = (state_nx == BIT_PULSE) && !shreg_nx[WIDTH-1];
    confirm_nx = (state_nx == CONF_PULSE);
    clear_nx   = (state_nx == CLR_PULSE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bits_left <= '0;
      enter0    <= 1'b0;
      enter1    <= 1'b0;
      confirm   <= 1'b0;
      clear     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      bits_left <= bits_left_nx;
      enter0    <= enter0_nx;
      enter1    <= enter1_nx;
      confirm   <= confirm_nx;
      clear     <= clear_nx;
    end
  end

  assign data_ready = (state == IDLE);
  assign busy       = !data_ready;

endmodule

// File: tb/tb_bit_entry_sequencer.sv
// Scoreboard bench for bit_entry_sequencer: default-parameter instance plus a
// fast P=1/G=1/WIDTH=4 instance; expected pulse events are queued at stimulus time.
module tb_bit_entry_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] a_data;
  logic [3:0] a_bc;
  logic       a_valid, a_abort;
  logic       a_ready, a_e0, a_e1, a_conf, a_clr, a_busy;
  logic [3:0] b_data;
  logic [2:0] b_bc;
  logic       b_valid, b_abort;
  logic       b_ready, b_e0, b_e1, b_conf, b_clr, b_busy;

  bit_entry_sequencer dut_a (
    .clock(clock), .reset(reset), .data_in(a_data), .bit_count(a_bc),
    .data_valid(a_valid), .data_ready(a_ready), .abort(a_abort),
    .enter0(a_e0), .enter1(a_e1), .confirm(a_conf), .clear(a_clr), .busy(a_busy)
  );

  bit_entry_sequencer #(.WIDTH(4), .PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset), .data_in(b_data), .bit_count(b_bc),
    .data_valid(b_valid), .data_ready(b_ready), .abort(b_abort),
    .enter0(b_e0), .enter1(b_e1), .confirm(b_conf), .clear(b_clr), .busy(b_busy)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Event kinds: base+0 enter0, +1 enter1, +2 confirm, +3 clear, +4 ready rise (len 0).
  typedef struct {
    int kind;
    int start;
    int len;
  } ev_t;
  ev_t exq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ex(input int kind, input int start, input int len);
    ev_t e;
    e.kind  = kind;
    e.start = start;
    e.len   = len;
    exq.push_back(e);
  endtask

  task automatic ex_word(input int base, input int t0, input logic [7:0] d,
                         input int n, input int p, input int g);
    for (int i = 0; i < n; i++) ex(base + (d[7-i] ? 1 : 0), t0 + 1 + i * (p + g), p);
    ex(base + 2, t0 + 1 + n * (p + g), p);
    ex(base + 4, t0 + 1 + (n + 1) * (p + g), 0);
  endtask

  task automatic got(input int kind, input int start, input int len);
    ev_t e;
    n_tests++;
    if (exq.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind %0d start %0d len %0d, expected no event", kind, start, len);
    end else begin
      e = exq.pop_front();
      if (kind != e.kind || start != e.start || len != e.len) begin
        n_fail++;
        $display("FAIL event: got kind %0d start %0d len %0d, expected kind %0d start %0d len %0d",
                 kind, start, len, e.kind, e.start, e.len);
      end
    end
  endtask

  bit         mon_on   = 1'b0;
  bit         mon_init = 1'b0;
  logic [9:0] sig, prev;
  int         st[10];

  always @(negedge clock) begin
    if (mon_on) begin
      sig = {b_ready, b_clr, b_conf, b_e1, b_e0, a_ready, a_clr, a_conf, a_e1, a_e0};
      if (!mon_init) begin
        prev     = sig;
        mon_init = 1'b1;
      end
      chk("a_onehot", {31'd0, $onehot0({a_e0, a_e1, a_conf, a_clr})}, 32'd1);
      chk("b_onehot", {31'd0, $onehot0({b_e0, b_e1, b_conf, b_clr})}, 32'd1);
      chk("a_busy", {31'd0, a_busy}, {31'd0, !a_ready});
      chk("b_busy", {31'd0, b_busy}, {31'd0, !b_ready});
      for (int k = 0; k < 10; k++) begin
        if (k % 5 == 4) begin
          if (sig[k] && !prev[k]) got(k, cyc, 0);
        end else begin
          if (sig[k] && !prev[k]) st[k] = cyc;
          if (!sig[k] && prev[k]) got(k, st[k], cyc - st[k]);
        end
      end
      prev = sig;
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic send_a(input logic [7:0] d, input logic [3:0] bc, output int t0);
    chk("a_ready_before_send", {31'd0, a_ready}, 32'd1);
    t0      = cyc;
    a_data  = d;
    a_bc    = bc;
    a_valid = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    a_data  = ~d;
    a_bc    = 4'd1;
  endtask

  task automatic send_b(input logic [3:0] d, input logic [2:0] bc, output int t0);
    chk("b_ready_before_send", {31'd0, b_ready}, 32'd1);
    t0      = cyc;
    b_data  = d;
    b_bc    = bc;
    b_valid = 1'b1;
    @(negedge clock);
    b_valid = 1'b0;
    b_data  = ~d;
    b_bc    = 3'd1;
  endtask

  initial begin
    int t0;
    reset = 1'b1;
    a_valid = 1'b0; a_abort = 1'b0; a_data = '0; a_bc = '0;
    b_valid = 1'b0; b_abort = 1'b0; b_data = '0; b_bc = '0;
    repeat (3) @(negedge clock);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_a_pulses", {28'd0, a_e0, a_e1, a_conf, a_clr}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst_b_pulses", {28'd0, b_e0, b_e1, b_conf, b_clr}, 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clock);

    // Full A5 word; a stray valid while busy must be ignored.
    send_a(8'hA5, 4'd8, t0);
    ex_word(0, t0, 8'hA5, 8, 4, 4);
    chk("a_busy_after_accept", {31'd0, a_busy}, 32'd1);
    goto(t0 + 20);
    a_valid = 1'b1; a_data = 8'hFF; a_bc = 4'd3;
    @(negedge clock);
    a_valid = 1'b0;
    goto(t0 + 73);

    // Short word, then bit_count=0 as full width.
    send_a(8'hC0, 4'd2, t0);
    ex_word(0, t0, 8'hC0, 2, 4, 4);
    goto(t0 + 25);
    send_a(8'h3C, 4'd0, t0);
    ex_word(0, t0, 8'h3C, 8, 4, 4);
    goto(t0 + 73);

    // Abort during the second bit pulse; a second abort during clear is ignored.
    send_a(8'hA5, 4'd8, t0);
    ex(1, t0 + 1, 4);
    ex(0, t0 + 9, 2);
    ex(3, t0 + 11, 4);
    ex(4, t0 + 19, 0);
    goto(t0 + 10);
    a_abort = 1'b1;
    @(negedge clock);
    a_abort = 1'b0;
    goto(t0 + 12);
    a_abort = 1'b1;
    @(negedge clock);
    a_abort = 1'b0;
    goto(t0 + 19);

    // Abort and valid together in IDLE: clear only.
    t0 = cyc;
    a_abort = 1'b1; a_valid = 1'b1; a_data = 8'hFF; a_bc = 4'd8;
    ex(3, t0 + 1, 4);
    ex(4, t0 + 9, 0);
    @(negedge clock);
    a_abort = 1'b0; a_valid = 1'b0;
    chk("a_ready_low_after_abort", {31'd0, a_ready}, 32'd0);
    goto(t0 + 8);
    chk("a_ready_low_cycle8", {31'd0, a_ready}, 32'd0);
    goto(t0 + 9);

    // Back-to-back with valid held high; second word accepted as ready returns.
    t0 = cyc;
    a_data = 8'hA5; a_bc = 4'd8; a_valid = 1'b1;
    ex_word(0, t0, 8'hA5, 8, 4, 4);
    ex_word(0, t0 + 73, 8'h81, 8, 4, 4);
    @(negedge clock);
    a_data = 8'h81; a_bc = 4'd0;
    goto(t0 + 74);
    a_valid = 1'b0;
    chk("a_b2b_first_pulse", {30'd0, a_e1, a_e0}, 32'd2);
    goto(t0 + 146);

    // Reset in cycle 30 of a word, then a fresh word.
    send_a(8'hA5, 4'd8, t0);
    ex(1, t0 + 1, 4);
    ex(0, t0 + 9, 4);
    ex(1, t0 + 17, 4);
    ex(0, t0 + 25, 4);
    ex(4, t0 + 31, 0);
    goto(t0 + 30);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_pulses", {28'd0, a_e0, a_e1, a_conf, a_clr}, 32'd0);
    chk("midrst_ready", {31'd0, a_ready}, 32'd1);
    send_a(8'h5A, 4'd8, t0);
    ex_word(0, t0, 8'h5A, 8, 4, 4);
    goto(t0 + 73);

    // Fast instance: 4'h9 then 4'h6 with count 0.
    send_b(4'h9, 3'd4, t0);
    ex_word(5, t0, 8'h90, 4, 1, 1);
    goto(t0 + 11);
    send_b(4'h6, 3'd0, t0);
    ex_word(5, t0, 8'h60, 4, 1, 1);
    goto(t0 + 11);

    repeat (5) @(negedge clock);
    while (exq.size() > 0) begin
      ev_t e;
      e = exq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_event: got none, expected kind %0d start %0d len %0d", e.kind, e.start, e.len);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
